// File: rtl/dm_mem_responder_if.sv
// Level-style memory handshake between a pipeline stage (master) and
// the memory responder (slave). Requests stay asserted until Valid pulses.
interface dm_mem_responder_if #(
    parameter int memAddrWidth = 15
) ();
    logic                    Mem_R;
    logic [3:0]              Mem_W;
    logic [memAddrWidth-1:0] Mem_Addr;
    logic [31:0]             Mem_WData;
    logic                    Valid;
    logic [31:0]             Mem_RData;
    logic                    Err;

    modport master (
        output Mem_R, Mem_W, Mem_Addr, Mem_WData,
        input  Valid, Mem_RData, Err
    );

    modport slave (
        input  Mem_R, Mem_W, Mem_Addr, Mem_WData,
        output Valid, Mem_RData, Err
    );
endinterface

// File: rtl/dm_mem_responder.sv
// Word-organised synchronous RAM with fixed access latency. Aligns low-aligned
// store data/masks onto byte lanes and right-justifies load data.
module dm_mem_responder #(
    parameter int memAddrWidth = 15,
    parameter int LATENCY      = 2
) (
    input  logic              clk,
    input  logic              rst,
    dm_mem_responder_if.slave mem_if
);
    localparam int IDXW  = memAddrWidth - 2;
    localparam int WORDS = 1 << IDXW;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [memAddrWidth-1:0] addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wmask_q;
    logic                    rd_q;
    logic [31:0]             rdata_q;

    logic                    req;
    logic                    accept;
    logic [IDXW-1:0]         rd_idx;
    logic [1:0]              off;
    logic [6:0]              mask_wide;
    logic [3:0]              lane_mask;
    logic                    misaligned;
    logic                    wr_en;
    logic [31:0]             wdata_sh;
    logic [31:0]             rd_shift;
    wire  [31:0]             ram_word;

    assign req    = mem_if.Mem_R | (mem_if.Mem_W != 4'b0000);
    assign accept = (state_q == IDLE) && req;

    // While idle the RAM is addressed straight from the bus so the word is
    // ready by the RESP cycle even at LATENCY=1; afterwards the latched
    // address keeps it stable.
    assign rd_idx = (state_q == IDLE) ? mem_if.Mem_Addr[memAddrWidth-1:2]
                                      : addr_q[memAddrWidth-1:2];

    assign off        = addr_q[1:0];
    assign mask_wide  = {3'b000, wmask_q} << off;
    assign lane_mask  = mask_wide[3:0];
    assign misaligned = |mask_wide[6:4];
    assign wdata_sh   = wdata_q << {off, 3'b000};
    assign rd_shift   = ram_word >> {off, 3'b000};
    assign wr_en      = (state_q == RESP) && !rst && !misaligned;

    // One byte-wide RAM per lane so each lane keeps a single write port.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] lane_rd_q;

            // Registered read plus lane-enabled write at the end of RESP.
            always_ff @(posedge clk) begin
                lane_rd_q <= lane_mem[rd_idx];
                if (wr_en && lane_mask[gi]) begin
                    lane_mem[addr_q[memAddrWidth-1:2]] <= wdata_sh[8*gi +: 8];
                end
            end

            assign ram_word[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

    // State, countdown and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            rd_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= mem_if.Mem_Addr;
                wdata_q <= mem_if.Mem_WData;
                wmask_q <= mem_if.Mem_W;
                rd_q    <= mem_if.Mem_R;
            end
            if (state_q == RESP && rd_q) begin
                rdata_q <= rd_shift;
            end
        end
    end

    // Next-state logic: dropping the request while waiting aborts the access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_if.Valid     = (state_q == RESP);
    assign mem_if.Err       = (state_q == RESP) && misaligned;
    assign mem_if.Mem_RData = (state_q == RESP && rd_q) ? rd_shift : rdata_q;

endmodule

// File: tb/tb_dm_mem_responder.sv
// Scoreboard bench: the driver pushes expected responses, per-DUT monitors
// pop and compare whenever Valid is seen. DUT0 has LATENCY=2, DUT1 LATENCY=1.
module tb_dm_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        int          cyc;
        bit          chk_rd;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_mem_responder_if #(.memAddrWidth(15)) bus0 ();
    dm_mem_responder_if #(.memAddrWidth(15)) bus1 ();

    dm_mem_responder #(.memAddrWidth(15), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .mem_if(bus0.slave));
    dm_mem_responder #(.memAddrWidth(15), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_if(bus1.slave));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", nm, got, req, cyc);
        end
    endtask

    // DUT0 monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus0.Valid === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dm0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dm0_valid_cycle", cyc, e.cyc);
                chk("dm0_err", {31'd0, bus0.Err}, {31'd0, e.err});
                if (e.chk_rd) chk("dm0_rdata", bus0.Mem_RData, e.rd);
                $display("dm0 resp cycle %0d rdata 0x%08h err %0b", cyc, bus0.Mem_RData, bus0.Err);
            end
        end
    end

    // DUT1 monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus1.Valid === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dm1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dm1_valid_cycle", cyc, e.cyc);
                chk("dm1_err", {31'd0, bus1.Err}, {31'd0, e.err});
                if (e.chk_rd) chk("dm1_rdata", bus1.Mem_RData, e.rd);
                $display("dm1 resp cycle %0d rdata 0x%08h err %0b", cyc, bus1.Mem_RData, bus1.Err);
            end
        end
    end

    task automatic drive(input int sel, input bit r, input logic [3:0] w,
                         input logic [14:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            bus0.Mem_R = r; bus0.Mem_W = w; bus0.Mem_Addr = a; bus0.Mem_WData = wd;
        end else begin
            bus1.Mem_R = r; bus1.Mem_W = w; bus1.Mem_Addr = a; bus1.Mem_WData = wd;
        end
    endtask

    // One full access: drive, push expectation, hold until Valid, release.
    task automatic acc(input int sel, input bit r, input logic [3:0] w,
                       input logic [14:0] a, input logic [31:0] wd,
                       input bit chk_rd, input logic [31:0] erd, input bit eerr);
        exp_t e;
        bit   seen;
        @(negedge clk);
        drive(sel, r, w, a, wd);
        e.cyc = cyc + ((sel == 0) ? 2 : 1);
        e.chk_rd = chk_rd; e.rd = erd; e.err = eerr;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = (sel == 0) ? (bus0.Valid === 1'b1) : (bus1.Valid === 1'b1);
        end
        if (!seen) chk("valid_timeout", 32'd0, 32'd1);
        drive(sel, 1'b0, 4'd0, 15'd0, 32'd0);
    endtask

    initial begin
        int c;
        drive(0, 1'b0, 4'd0, 15'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 15'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_valid0", {31'd0, bus0.Valid}, 32'd0);
        chk("rst_err0",   {31'd0, bus0.Err},   32'd0);
        chk("rst_rdata0", bus0.Mem_RData,      32'd0);
        chk("rst_valid1", {31'd0, bus1.Valid}, 32'd0);
        chk("rst_rdata1", bus1.Mem_RData,      32'd0);
        rst = 1'b0;

        // Word store then load
        acc(0, 0, 4'b1111, 15'h0010, 32'hDEADBEEF, 0, 32'd0, 0);
        acc(0, 1, 4'b0000, 15'h0010, 32'd0,        1, 32'hDEADBEEF, 0);
        // Byte store onto a known word
        acc(0, 0, 4'b1111, 15'h0010, 32'h11223344, 0, 32'd0, 0);
        acc(0, 0, 4'b0001, 15'h0012, 32'h000000AB, 0, 32'd0, 0);
        acc(0, 1, 4'b0000, 15'h0010, 32'd0,        1, 32'h11AB3344, 0);
        acc(0, 1, 4'b0000, 15'h0012, 32'd0,        1, 32'h000011AB, 0);
        // Misaligned half store: Err, no write
        acc(0, 0, 4'b0011, 15'h0013, 32'h0000FFFF, 0, 32'd0, 1);
        acc(0, 1, 4'b0000, 15'h0010, 32'd0,        1, 32'h11AB3344, 0);
        // Aligned half store at offset 2, then misaligned reads
        acc(0, 0, 4'b0011, 15'h0012, 32'h00005566, 0, 32'd0, 0);
        acc(0, 1, 4'b0000, 15'h0013, 32'd0,        1, 32'h00000055, 0);
        acc(0, 1, 4'b0000, 15'h0011, 32'd0,        1, 32'h00556633, 0);
        // Misaligned word store: Err, word unchanged
        acc(0, 0, 4'b1111, 15'h0011, 32'hFFFFFFFF, 0, 32'd0, 1);
        acc(0, 1, 4'b0000, 15'h0010, 32'd0,        1, 32'h55663344, 0);

        // Back-to-back: Mem_R held 12 cycles -> Valid at +2, +5, +8, +11
        @(negedge clk);
        drive(0, 1'b1, 4'd0, 15'h0010, 32'd0);
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.cyc = c + 2 + 3 * k; e.chk_rd = 1; e.rd = 32'h55663344; e.err = 0;
            q0.push_back(e);
        end
        repeat (12) @(negedge clk);
        drive(0, 1'b0, 4'd0, 15'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Abort: write request dropped in the WAIT cycle
        drive(0, 1'b0, 4'b1111, 15'h0010, 32'hCAFEF00D);
        @(negedge clk);
        drive(0, 1'b0, 4'd0, 15'd0, 32'd0);
        repeat (3) @(negedge clk);
        acc(0, 1, 4'b0000, 15'h0010, 32'd0, 1, 32'h55663344, 0);

        // Reset during WAIT: no Valid, no write, Mem_RData cleared
        @(negedge clk);
        drive(0, 1'b0, 4'b1111, 15'h0010, 32'h12345678);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 4'd0, 15'd0, 32'd0);
        chk("midrst_valid", {31'd0, bus0.Valid}, 32'd0);
        chk("midrst_rdata", bus0.Mem_RData, 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_idle_valid", {31'd0, bus0.Valid}, 32'd0);
        acc(0, 1, 4'b0000, 15'h0010, 32'd0, 1, 32'h55663344, 0);

        // LATENCY=1: simultaneous read+write returns pre-write word
        acc(1, 0, 4'b1111, 15'h0020, 32'h00000005, 0, 32'd0, 0);
        acc(1, 1, 4'b1111, 15'h0020, 32'h00000009, 1, 32'h00000005, 0);
        acc(1, 1, 4'b0000, 15'h0020, 32'd0,        1, 32'h00000009, 0);
        acc(1, 0, 4'b0001, 15'h0023, 32'h00000077, 0, 32'd0, 0);
        acc(1, 1, 4'b0000, 15'h0020, 32'd0,        1, 32'h77000009, 0);
        acc(1, 1, 4'b0000, 15'h0023, 32'd0,        1, 32'h00000077, 0);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t required completion", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end
endmodule
